// File: rtl/dff_mask_counter.sv
// Up/down counter with async reset, masked synchronous clear, parallel load,
// programmable modulo, wrap/saturate mode, a wrap pulse and a sticky overflow flag.
// Optional snapshot register is enabled with `define DFF_MASK_COUNTER_SNAP_EN.
module dff_mask_counter #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] CLR_MASK = WIDTH'(8'h0F),
    parameter longint           MODULO   = 0,
    parameter int               SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             snap,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             ovf,
    output logic [WIDTH-1:0] snap_q
);

    localparam logic [WIDTH-1:0] TOP = (MODULO == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    // Clamping is only needed when the range is narrower than the full WIDTH-bit space.
    localparam bit CLAMP = (MODULO != 0) && (MODULO < (longint'(1) << WIDTH));

    logic [WIDTH-1:0] clr_raw;
    logic [WIDTH-1:0] clr_val;
    logic [WIDTH-1:0] ld_val;

    assign clr_raw = q & ~CLR_MASK;

    generate
        if (CLAMP) begin : g_clamp
            assign clr_val = (clr_raw > TOP) ? TOP : clr_raw;
            assign ld_val  = (d > TOP) ? TOP : d;
        end else begin : g_noclamp
            assign clr_val = clr_raw;
            assign ld_val  = d;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else if (clr) begin
            q    <= clr_val;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else if (ld) begin
            q    <= ld_val;
            wrap <= 1'b0;
        end else if (en) begin
            if (up) begin
                if (q == TOP) begin
                    q    <= (SATURATE != 0) ? q : '0;
                    wrap <= 1'b1;
                    ovf  <= 1'b1;
                end else begin
                    q    <= q + ONE;
                    wrap <= 1'b0;
                end
            end else begin
                if (q == '0) begin
                    q    <= (SATURATE != 0) ? q : TOP;
                    wrap <= 1'b1;
                    ovf  <= 1'b1;
                end else begin
                    q    <= q - ONE;
                    wrap <= 1'b0;
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

`ifdef DFF_MASK_COUNTER_SNAP_EN
    // Captures the pre-update value, independent of clr/ld/en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q <= '0;
        end else if (snap) begin
            snap_q <= q;
        end
    end
`else
    logic unused_snap;
    assign unused_snap = snap;
    assign snap_q      = '0;
`endif

endmodule
